// File: rtl/ascon128_decrypt.sv
// ---------------------------------------------------------------------------
// ascon128_decrypt
//   Single-block Ascon-style authenticated decryption. The 320-bit state is
//   built from IV, key and nonce. It is permuted, one ciphertext block is
//   absorbed, the state is keyed and permuted again, and the resulting tag
//   is compared with the received one. The recovered block is released only
//   when the tags match; otherwise plaintext is forced to zero.
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset
//     start       level request; accepted only in DEC_IDLE
//     key         128-bit secret key
//     nonce       128-bit public nonce
//     ciphertext  128-bit ciphertext block
//     tag_in      128-bit received tag
//     plaintext   recovered block (zero unless authenticated)
//     auth_ok     computed tag equals tag_in
//     busy        high from DEC_INIT through DEC_CHECK
//     done        high while in DEC_DONE
//
// ascon_permutation
//   Iterative Ascon permutation, one round per clock. It runs the last
//   `rounds` rounds of the 12-round schedule.
//
//   Handshake: the caller raises start and holds it. When the final round
//   has been applied, done rises and stays high until start is seen low.
//   The caller should not raise start again while done is still high.
//
//   Ports
//     clk, rst_n   clock and asynchronous active-low reset
//     start        request (level)
//     rounds       number of rounds, 0..12
//     state_in     state loaded when the request is taken
//     state_out    permuted state, valid while done=1
//     done         permutation complete
// ---------------------------------------------------------------------------

module ascon_permutation (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [4:0]   rounds,
    input  logic [319:0] state_in,
    output logic [319:0] state_out,
    output logic         done
);

    typedef enum logic [1:0] {P_IDLE, P_RUN, P_DONE} perm_state_e;

    perm_state_e  pst_q, pst_d;
    logic [319:0] s_q, s_d;
    logic [3:0]   rnd_q, rnd_d;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        // Round constant for schedule index r is {0xf - r, r}.
        x2 = x2 ^ {56'd0, 4'hf - r, r};
        // Bitsliced 5-bit S-box.
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        // Linear diffusion layer.
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pst_q <= P_IDLE;
            s_q   <= '0;
            rnd_q <= '0;
        end else begin
            pst_q <= pst_d;
            s_q   <= s_d;
            rnd_q <= rnd_d;
        end
    end

    always_comb begin
        pst_d = pst_q;
        s_d   = s_q;
        rnd_d = rnd_q;
        case (pst_q)
            P_IDLE: begin
                if (start) begin
                    s_d   = state_in;
                    // Start part-way into the schedule so that exactly `rounds` rounds remain.
                    rnd_d = (rounds >= 5'd12) ? 4'd0 : 4'(5'd12 - rounds);
                    pst_d = P_RUN;
                end
            end
            P_RUN: begin
                if (rnd_q >= 4'd12) begin
                    pst_d = P_DONE;
                end else begin
                    s_d   = ascon_round(s_q, rnd_q);
                    rnd_d = rnd_q + 4'd1;
                end
            end
            P_DONE: begin
                if (!start) pst_d = P_IDLE;
            end
            default: pst_d = P_IDLE;
        endcase
    end

    assign state_out = s_q;
    assign done      = (pst_q == P_DONE);

endmodule

module ascon128_decrypt #(
    parameter logic [63:0] IV = 64'h80400c0600000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic [127:0] ciphertext,
    input  logic [127:0] tag_in,
    output logic [127:0] plaintext,
    output logic         auth_ok,
    output logic         busy,
    output logic         done
);

    typedef enum logic [3:0] {
        DEC_IDLE, DEC_INIT, DEC_PERM_A, DEC_ABSORB, DEC_PERM_B,
        DEC_SQUEEZE, DEC_FINAL, DEC_CHECK, DEC_DONE
    } dec_state_e;

    dec_state_e   state_q, state_d;
    logic [319:0] s_q, s_d;
    logic [127:0] key_q, key_d, nonce_q, nonce_d, ct_q, ct_d, tag_q, tag_d;
    logic [127:0] pt_q, pt_d, calc_tag_q, calc_tag_d;
    logic [127:0] plaintext_q, plaintext_d;
    logic         auth_ok_q, auth_ok_d;
    logic [4:0]   rounds_q, rounds_d;
    logic         perm_start_q, perm_start_d;
    logic [319:0] perm_in_q, perm_in_d;
    logic [319:0] perm_out;
    logic         perm_done;
    logic         in_perm, perm_load, perm_finish;

    ascon_permutation u_perm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (perm_start_q),
        .rounds    (rounds_q),
        .state_in  (perm_in_q),
        .state_out (perm_out),
        .done      (perm_done)
    );

    // Permutation handshake (shared by every DEC_PERM_x state).
    //   perm_load:   no request pending and the previous done has already
    //                dropped, so a new request may be issued.
    //   perm_finish: the request is pending and done is seen high. Capture
    //                the result and drop the request on the same cycle.
    assign in_perm     = (state_q == DEC_PERM_A) || (state_q == DEC_PERM_B) || (state_q == DEC_FINAL);
    assign perm_load   = !perm_start_q && !perm_done;
    assign perm_finish = perm_start_q && perm_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DEC_IDLE;
            s_q          <= '0;
            key_q        <= '0;
            nonce_q      <= '0;
            ct_q         <= '0;
            tag_q        <= '0;
            pt_q         <= '0;
            calc_tag_q   <= '0;
            plaintext_q  <= '0;
            auth_ok_q    <= 1'b0;
            rounds_q     <= '0;
            perm_start_q <= 1'b0;
            perm_in_q    <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            ct_q         <= ct_d;
            tag_q        <= tag_d;
            pt_q         <= pt_d;
            calc_tag_q   <= calc_tag_d;
            plaintext_q  <= plaintext_d;
            auth_ok_q    <= auth_ok_d;
            rounds_q     <= rounds_d;
            perm_start_q <= perm_start_d;
            perm_in_q    <= perm_in_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        key_d        = key_q;
        nonce_d      = nonce_q;
        ct_d         = ct_q;
        tag_d        = tag_q;
        pt_d         = pt_q;
        calc_tag_d   = calc_tag_q;
        plaintext_d  = plaintext_q;
        auth_ok_d    = auth_ok_q;
        rounds_d     = rounds_q;
        perm_start_d = perm_start_q;
        perm_in_d    = perm_in_q;

        if (in_perm) begin
            if (perm_load) begin
                perm_in_d    = s_q;
                perm_start_d = 1'b1;
            end else if (perm_finish) begin
                perm_start_d = 1'b0;
            end
        end

        case (state_q)
            DEC_IDLE: begin
                if (start) begin
                    key_d       = key;
                    nonce_d     = nonce;
                    ct_d        = ciphertext;
                    tag_d       = tag_in;
                    auth_ok_d   = 1'b0;
                    // Drop the previous block as well so that an old result
                    // is never shown next to a new, unfinished one.
                    plaintext_d = '0;
                    state_d     = DEC_INIT;
                end
            end
            DEC_INIT: begin
                s_d      = {IV, key_q, nonce_q};
                rounds_d = 5'd12;
                state_d  = DEC_PERM_A;
            end
            DEC_PERM_A: begin
                if (perm_finish) begin
                    s_d     = {perm_out[319:256], perm_out[255:128] ^ key_q, perm_out[127:0]};
                    state_d = DEC_ABSORB;
                end
            end
            DEC_ABSORB: begin
                pt_d          = s_q[127:0] ^ ct_q;
                s_d[127:0]    = ct_q;
                rounds_d      = 5'd6;
                state_d       = DEC_PERM_B;
            end
            DEC_PERM_B: begin
                if (perm_finish) begin
                    s_d     = perm_out;
                    state_d = DEC_SQUEEZE;
                end
            end
            DEC_SQUEEZE: begin
                s_d[191:128] = s_q[191:128] ^ key_q[127:64];
                s_d[127:64]  = s_q[127:64]  ^ key_q[63:0];
                rounds_d     = 5'd12;
                state_d      = DEC_FINAL;
            end
            DEC_FINAL: begin
                if (perm_finish) begin
                    calc_tag_d = perm_out[255:128] ^ key_q;
                    state_d    = DEC_CHECK;
                end
            end
            DEC_CHECK: begin
                if (calc_tag_q == tag_q) begin
                    auth_ok_d   = 1'b1;
                    plaintext_d = pt_q;
                end else begin
                    auth_ok_d   = 1'b0;
                    plaintext_d = '0;
                end
                state_d = DEC_DONE;
            end
            DEC_DONE: begin
                // Leaving only on start=0 means a held start cannot retrigger.
                if (!start) state_d = DEC_IDLE;
            end
            default: state_d = DEC_IDLE;
        endcase
    end

    assign plaintext = plaintext_q;
    assign auth_ok   = auth_ok_q;
    assign busy      = (state_q != DEC_IDLE) && (state_q != DEC_DONE);
    assign done      = (state_q == DEC_DONE);

endmodule

// File: tb/tb_ascon128_decrypt.sv
// Bench for ascon128_decrypt. Expected results come from an encryption
// reference model: an untampered round trip must return the original block
// with auth_ok=1, and any tampered input must give auth_ok=0 with a zero block.
module tb_ascon128_decrypt;

  localparam logic [63:0]  IV = 64'h80400c0600000000;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] N0 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P0 = 128'h202122232425262728292a2b2c2d2e2f;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [127:0] key = '0, nonce = '0, ciphertext = '0, tag_in = '0;
  logic [127:0] plaintext;
  logic auth_ok, busy, done;

  always #5 clk = ~clk;

  ascon128_decrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key        (key),
    .nonce      (nonce),
    .ciphertext (ciphertext),
    .tag_in     (tag_in),
    .plaintext  (plaintext),
    .auth_ok    (auth_ok),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [128:0] exp_q[$];   // {auth_ok, plaintext}

  task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Permutation written column-wise: S-box in algebraic normal form,
  // x0 is the most significant bit of each 5-bit column.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int nr);
    logic [63:0] x[5];
    logic [63:0] y[5];
    int ra[5];
    int rb[5];
    logic a, b, c, d, e;
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int j = 0; j < 64; j++) begin
        a = x[0][j]; b = x[1][j]; c = x[2][j]; d = x[3][j]; e = x[4][j];
        y[0][j] = (e & b) ^ d ^ (c & b) ^ c ^ (b & a) ^ b ^ a;
        y[1][j] = e ^ (d & c) ^ (d & b) ^ d ^ (c & b) ^ c ^ b ^ a;
        y[2][j] = (e & d) ^ e ^ c ^ b ^ 1'b1;
        y[3][j] = (e & a) ^ e ^ (d & a) ^ d ^ c ^ b ^ a;
        y[4][j] = (e & b) ^ e ^ d ^ (b & a) ^ b;
      end
      for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], ra[i]) ^ rotr(y[i], rb[i]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic ref_encrypt(input logic [127:0] k, n, p, output logic [127:0] ct, tg);
    logic [319:0] s;
    s = ref_perm({IV, k, n}, 12);
    s[255:128] = s[255:128] ^ k;
    ct = s[127:0] ^ p;
    s[127:0] = ct;
    s = ref_perm(s, 6);
    s[191:128] = s[191:128] ^ k[127:64];
    s[127:64]  = s[127:64] ^ k[63:0];
    s = ref_perm(s, 12);
    tg = s[255:128] ^ k;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string tag);
    logic [128:0] exp;
    bit busy_seen = 0;
    bit early = 0;
    int cyc = 0;
    while (!done && cyc < 500) begin
      if (busy) busy_seen = 1;
      if (auth_ok) early = 1;
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy_seen"}, busy_seen, 1);
    check_eq({tag, "_auth_before_done"}, early, 0);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    exp = exp_q.pop_front();
    check_eq({tag, "_auth_ok"}, auth_ok, exp[128]);
    check_eq({tag, "_plaintext"}, plaintext, exp[127:0]);
  endtask

  // Apply one operation; start is held for start_cycles edges, then every
  // input is scrambled while the block is busy.
  task automatic run_op(input string tag, input logic [127:0] k, n, c, t,
                        input logic [128:0] exp, input int start_cycles);
    exp_q.push_back(exp);
    @(negedge clk);
    key = k; nonce = n; ciphertext = c; tag_in = t; start = 1'b1;
    repeat (start_cycles) @(negedge clk);
    start = 1'b0;
    key = rand128(); nonce = rand128(); ciphertext = rand128(); tag_in = rand128();
    wait_done(tag);
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] c0, t0, kr, nr, pr, cr, tr;
  int rises, cyc, tamper;
  logic prev;

  initial begin
    ref_encrypt(K0, N0, P0, c0, t0);

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_plaintext", plaintext, 0);
    check_eq("rst_auth_ok", auth_ok, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_perm_start", dut.perm_start_q, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Known-answer round trip, tag bit 0 flipped, ciphertext bit 127 flipped
    run_op("r33", K0, N0, c0, t0, {1'b1, P0}, 1);
    run_op("r34", K0, N0, c0, t0 ^ 128'd1, {1'b0, 128'd0}, 1);
    run_op("r35", K0, N0, c0 ^ {1'b1, 127'd0}, t0, {1'b0, 128'd0}, 1);

    // start held three cycles, inputs changed mid-operation
    run_op("r36", K0, N0, c0, t0, {1'b1, P0}, 3);
    repeat (3) @(negedge clk);
    check_eq("r36_single_op_busy", busy, 0);
    check_eq("r36_single_op_done", done, 0);

    // start held through DEC_DONE: no retrigger, done held until start drops
    exp_q.push_back({1'b1, P0});
    @(negedge clk);
    key = K0; nonce = N0; ciphertext = c0; tag_in = t0; start = 1'b1;
    @(negedge clk);
    ciphertext = rand128();
    wait_done("hold");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("hold_done_kept", done, 1);
      check_eq("hold_no_retrigger", busy, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check_eq("hold_done_drop", done, 0);
    check_eq("hold_auth_kept", auth_ok, 1);
    check_eq("hold_pt_kept", plaintext, P0);

    // Reset while idle with a held result
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_idle_auth_ok", auth_ok, 0);
    check_eq("rst_idle_plaintext", plaintext, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during the second permutation
    @(negedge clk);
    key = K0; nonce = N0; ciphertext = c0; tag_in = t0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; cyc = 0; prev = dut.perm_start_q;
    while (rises < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (dut.perm_start_q && !prev) rises++;
      prev = dut.perm_start_q;
    end
    repeat (4) @(negedge clk);
    check_eq("r37_reached_perm_b", rises, 2);
    check_eq("r37_busy_before", busy, 1);
    check_eq("r37_perm_start_before", dut.perm_start_q, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("r37_busy", busy, 0);
    check_eq("r37_done", done, 0);
    check_eq("r37_auth_ok", auth_ok, 0);
    check_eq("r37_plaintext", plaintext, 0);
    check_eq("r37_perm_start", dut.perm_start_q, 0);
    check_eq("r37_state_reg", dut.s_q, 0);
    check_eq("r37_pt_reg", dut.pt_q, 0);
    check_eq("r37_calc_tag", dut.calc_tag_q, 0);
    check_eq("r37_key_copy", dut.key_q, 0);
    check_eq("r37_tag_copy", dut.tag_q, 0);
    exp_q.push_back({1'b1, P0});
    key = K0; nonce = N0; ciphertext = c0; tag_in = t0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("r37_accept_first_edge", busy, 1);
    start = 1'b0;
    wait_done("r37_after");

    // Back-to-back: failing then passing
    run_op("r38_a", K0, N0, c0, t0 ^ 128'd1, {1'b0, 128'd0}, 1);
    run_op("r38_b", K0, N0, c0, t0, {1'b1, P0}, 1);

    // Randomised round trips with optional single-bit tampering
    for (int i = 0; i < 10; i++) begin
      kr = rand128(); nr = rand128(); pr = rand128();
      ref_encrypt(kr, nr, pr, cr, tr);
      tamper = $urandom_range(0, 2);
      if (tamper == 1) tr = tr ^ (128'd1 << $urandom_range(0, 127));
      if (tamper == 2) cr = cr ^ (128'd1 << $urandom_range(0, 127));
      run_op($sformatf("rand%0d", i), kr, nr, cr, tr,
             (tamper == 0) ? {1'b1, pr} : {1'b0, 128'd0}, $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
